// File: rtl/hazard_sequencer_if.sv
// Bundle between the hazard sequencer and the pipeline: hazard inputs from ID/EX/MEM,
// PC and pipeline-register controls plus statistics back out.
interface hazard_sequencer_if #(
  parameter int CNT_W = 32
) ();
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_uses_rs2;
  logic             ex_mem_read;
  logic [4:0]       ex_rd;
  logic             branch_taken;
  logic             dmem_busy;
  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             pipe_hold;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_events;

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs2, ex_mem_read, ex_rd, branch_taken, dmem_busy,
    output pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold, state,
           stall_cycles, flush_events
  );

  modport master (
    output id_rs1, id_rs2, id_uses_rs2, ex_mem_read, ex_rd, branch_taken, dmem_busy,
    input  pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold, state,
           stall_cycles, flush_events
  );
endinterface

// File: rtl/hazard_sequencer.sv
// Hazard controller for the 5-stage core: load-use stalls, taken-branch squash and
// data-memory wait states, with saturating stall/flush statistics.
module hazard_sequencer #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic               clk,
  input  logic               reset,
  hazard_sequencer_if.slave  bus
);

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_FLUSH = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

  logic [1:0]       r_state;
  logic [1:0]       r_resume;
  logic [2:0]       r_flush_left;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic             w_lu;
  logic             w_pc_write;
  logic             w_ifid_write;
  logic             w_ifid_flush;
  logic             w_idex_bubble;
  logic             w_pipe_hold;
  logic             w_branch_accept;
  logic [1:0]       w_next_state;
  logic [1:0]       w_next_resume;
  logic [2:0]       w_next_flush_left;

  assign w_lu = bus.ex_mem_read && (bus.ex_rd != 5'd0) &&
                ((bus.ex_rd == bus.id_rs1) ||
                 (bus.id_uses_rs2 && (bus.ex_rd == bus.id_rs2)));

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    w_pc_write        = 1'b1;
    w_ifid_write      = 1'b1;
    w_ifid_flush      = 1'b0;
    w_idex_bubble     = 1'b0;
    w_pipe_hold       = 1'b0;
    w_branch_accept   = 1'b0;
    w_next_state      = r_state;
    w_next_resume     = r_resume;
    w_next_flush_left = r_flush_left;

    case (r_state)
      S_RUN: begin
        if (bus.dmem_busy) begin
          w_pc_write    = 1'b0;
          w_ifid_write  = 1'b0;
          w_pipe_hold   = 1'b1;
          w_next_resume = S_RUN;
          w_next_state  = S_WAIT;
        end else if (bus.branch_taken) begin
          w_ifid_flush    = 1'b1;
          w_idex_bubble   = 1'b1;
          w_branch_accept = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            w_next_flush_left = FLUSH_RELOAD;
            w_next_state      = S_FLUSH;
          end
        end else if (w_lu) begin
          // Single-cycle stall: the load moves on to MEM and the hazard disappears.
          w_pc_write    = 1'b0;
          w_ifid_write  = 1'b0;
          w_idex_bubble = 1'b1;
        end
      end
      S_FLUSH: begin
        if (bus.dmem_busy) begin
          w_pc_write    = 1'b0;
          w_ifid_write  = 1'b0;
          w_pipe_hold   = 1'b1;
          w_next_resume = S_FLUSH;
          w_next_state  = S_WAIT;
        end else begin
          w_ifid_flush      = 1'b1;
          w_idex_bubble     = 1'b1;
          w_next_flush_left = r_flush_left - 3'd1;
          if (r_flush_left == 3'd1) w_next_state = S_RUN;
        end
      end
      S_WAIT: begin
        // Hold covers the busy cycles plus the one on which busy drops.
        w_pc_write   = 1'b0;
        w_ifid_write = 1'b0;
        w_pipe_hold  = 1'b1;
        if (!bus.dmem_busy) w_next_state = r_resume;
      end
      default: begin
        w_next_state = S_RUN;
      end
    endcase

    if (reset) begin
      w_pc_write      = 1'b0;
      w_ifid_write    = 1'b0;
      w_ifid_flush    = 1'b1;
      w_idex_bubble   = 1'b1;
      w_pipe_hold     = 1'b0;
      w_branch_accept = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      r_state      <= S_RUN;
      r_resume     <= S_RUN;
      r_flush_left <= 3'd0;
      r_stall_cnt  <= '0;
      r_flush_cnt  <= '0;
    end else begin
      r_state      <= w_next_state;
      r_resume     <= w_next_resume;
      r_flush_left <= w_next_flush_left;
      if (!w_pc_write && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_branch_accept && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign bus.pc_write     = w_pc_write;
  assign bus.ifid_write   = w_ifid_write;
  assign bus.ifid_flush   = w_ifid_flush;
  assign bus.idex_bubble  = w_idex_bubble;
  assign bus.pipe_hold    = w_pipe_hold;
  assign bus.state        = r_state;
  assign bus.stall_cycles = r_stall_cnt;
  assign bus.flush_events = r_flush_cnt;

endmodule
